keypad_emulator: RTL and testbench

Synthesizable 4x4 matrix-keypad model: the responder side of the column-drive/row-sense interface used by `scanner_fsm`. A command port presses a single key for a set time. The block answers the scanner's column drive on its row lines and adds pseudo-random contact bounce on both make and break. It is used in loopback benches and on-board self-test, where it replaces the physical keypad.

---
 rtl/keypad_emulator.sv | 150 +++++++++++++++
 tb/tb_keypad_emulator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Purpose: 4x4 matrix-keypad responder; presses one commanded key with LFSR contact bounce on make and break.
// Latency: row_q follows contact and col_d by 1 clock; a command occupies the block for 2*BOUNCE+hold+GAP cycles.
// Backpressure: cmd_ready is high only in IDLE; a command offered while busy waits, unconsumed, until then.
module keypad_emulator #(
    parameter int unsigned BOUNCE_CYCLES = 8,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [3:0]  col_d,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [15:0] cmd_hold,
    output logic [3:0]  row_q,
    output logic        key_down,
    output logic        busy
);

    // The down-counter must hold the longest of the bounce window, the gap
    // and a 16-bit hold time.
    localparam int unsigned MAX_PHASE = (BOUNCE_CYCLES > GAP_CYCLES) ? BOUNCE_CYCLES : GAP_CYCLES;
    localparam int unsigned PHASE_W   = ($clog2(MAX_PHASE) < 1) ? 1 : $clog2(MAX_PHASE);
    localparam int unsigned CNT_W     = (PHASE_W > 16) ? PHASE_W : 16;

    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_BOUNCE = 3'd1,
        ST_HOLD         = 3'd2,
        ST_REL_BOUNCE   = 3'd3,
        ST_GAP          = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [3:0]       key_q, key_d;
    logic [15:0]      hold_q, hold_d;
    logic [7:0]       lfsr_next;
    logic             contact;
    logic             cnt_zero;
    logic             col_hit;
    logic [3:0]       row_onehot;

    // x^8+x^6+x^5+x^4+1, shifting left.
    assign lfsr_next  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign cnt_zero   = (cnt_q == '0);
    assign col_hit    = col_d[key_q[1:0]];
    assign row_onehot = 4'b0001 << key_q[3:2];
    assign busy       = ~cmd_ready;

    // State, counter, LFSR and latched command registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            key_q   <= 4'd0;
            hold_q  <= 16'd1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            key_q   <= key_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state, contact level and status decode for the press sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_q;
        key_d     = key_q;
        hold_d    = hold_q;
        contact   = 1'b0;
        cmd_ready = 1'b0;
        key_down  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    key_d   = cmd_key;
                    // A zero hold still gives one stably-closed cycle.
                    hold_d  = (cmd_hold == 16'd0) ? 16'd1 : cmd_hold;
                    cnt_d   = BOUNCE_LOAD;
                    state_d = ST_PRESS_BOUNCE;
                end
            end
            ST_PRESS_BOUNCE: begin
                contact = lfsr_q[0];
                lfsr_d  = lfsr_next;
                if (cnt_zero) begin
                    cnt_d   = CNT_W'(hold_q) - CNT_W'(1);
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                contact  = 1'b1;
                key_down = 1'b1;
                if (cnt_zero) begin
                    cnt_d   = BOUNCE_LOAD;
                    state_d = ST_REL_BOUNCE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_REL_BOUNCE: begin
                // Continues the press-bounce sequence rather than reseeding.
                contact = lfsr_q[0];
                lfsr_d  = lfsr_next;
                if (cnt_zero) begin
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                // Contact forced open so the scanner always sees a release.
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Row sense: only the pressed key's column bit matters; other drive bits are ignored.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            row_q <= 4'b0000;
        end else begin
            row_q <= (contact && col_hit) ? row_onehot : 4'b0000;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
`timescale 1ns/1ps
module tb_keypad_emulator;

    logic        clk;
    logic        nrst;
    logic [3:0]  col_d;
    logic [2:0]  cmd_valid;
    logic [3:0]  cmd_key  [3];
    logic [15:0] cmd_hold [3];
    logic [2:0]  cmd_ready;
    logic [2:0]  key_down;
    logic [2:0]  busy;
    logic [3:0]  row_q    [3];

    int n_checks;
    int n_errors;

    // Instance parameters: index 0 = (B2,G1), 1 = (B4,G4), 2 = (B8,G4).
    int BP [3] = '{2, 4, 8};
    int GP [3] = '{1, 4, 4};

    keypad_emulator #(.BOUNCE_CYCLES(2), .GAP_CYCLES(1), .LFSR_SEED(8'hA5)) u_kp0 (
        .clk(clk), .nrst(nrst), .col_d(col_d), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_key(cmd_key[0]), .cmd_hold(cmd_hold[0]), .row_q(row_q[0]), .key_down(key_down[0]), .busy(busy[0]));
    keypad_emulator #(.BOUNCE_CYCLES(4), .GAP_CYCLES(4), .LFSR_SEED(8'hA5)) u_kp1 (
        .clk(clk), .nrst(nrst), .col_d(col_d), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_key(cmd_key[1]), .cmd_hold(cmd_hold[1]), .row_q(row_q[1]), .key_down(key_down[1]), .busy(busy[1]));
    keypad_emulator #(.BOUNCE_CYCLES(8), .GAP_CYCLES(4), .LFSR_SEED(8'hA5)) u_kp2 (
        .clk(clk), .nrst(nrst), .col_d(col_d), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_key(cmd_key[2]), .cmd_hold(cmd_hold[2]), .row_q(row_q[2]), .key_down(key_down[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each accepted command becomes a per-cycle schedule of {key_down, contact}
    // built from the press rules; the bounce bits are drawn from a plain LFSR.
    logic [7:0] m_lfsr [3];
    logic [1:0] m_sch  [3][128];
    int         m_pos  [3];
    int         m_len  [3];
    logic [3:0] m_key  [3];
    logic [3:0] m_row  [3];

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic model_accept(input int i);
        int h;
        int n;
        h = (cmd_hold[i] == 16'd0) ? 1 : int'(cmd_hold[i]);
        m_key[i] = cmd_key[i];
        n = 0;
        for (int j = 0; j < BP[i]; j++) begin m_sch[i][n] = {1'b0, m_lfsr[i][0]}; m_lfsr[i] = lfsr_step(m_lfsr[i]); n++; end
        for (int j = 0; j < h; j++)     begin m_sch[i][n] = 2'b11; n++; end
        for (int j = 0; j < BP[i]; j++) begin m_sch[i][n] = {1'b0, m_lfsr[i][0]}; m_lfsr[i] = lfsr_step(m_lfsr[i]); n++; end
        for (int j = 0; j < GP[i]; j++) begin m_sch[i][n] = 2'b00; n++; end
        m_len[i] = n;
        m_pos[i] = 0;
    endtask

    initial begin
        logic cur;
        for (int i = 0; i < 3; i++) begin
            m_pos[i] = 0; m_len[i] = 0; m_lfsr[i] = 8'hA5; m_row[i] = 4'd0; m_key[i] = 4'd0;
        end
        forever begin
            @(posedge clk or negedge nrst);
            for (int i = 0; i < 3; i++) begin
                if (!nrst) begin
                    m_pos[i] = 0; m_len[i] = 0; m_lfsr[i] = 8'hA5; m_row[i] = 4'd0;
                end else begin
                    cur = (m_pos[i] < m_len[i]) ? m_sch[i][m_pos[i]][0] : 1'b0;
                    m_row[i] = (cur && col_d[m_key[i][1:0]]) ? 4'(4'b0001 << m_key[i][3:2]) : 4'b0000;
                    if (m_pos[i] < m_len[i]) m_pos[i]++;
                    else if (cmd_valid[i]) model_accept(i);
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [6:0] exp_v;
        logic [6:0] act_v;
        logic       idle;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                idle  = (m_pos[i] >= m_len[i]);
                exp_v = {m_row[i], (idle ? 1'b0 : m_sch[i][m_pos[i]][1]), idle, ~idle};
                act_v = {row_q[i], key_down[i], cmd_ready[i], busy[i]};
                check($sformatf("model_inst%0d {row,kd,rdy,busy}", i), int'(act_v), int'(exp_v));
            end
        end
    endtask

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        while (!cmd_ready[i] && n < 200) begin @(negedge clk); n++; end
    endtask

    // One command; samples are taken at negedges, s = posedges since acceptance.
    task automatic run_txn(input int i, input logic [3:0] key, input logic [15:0] hold,
                           input bit rot, input logic [3:0] cval,
                           output int kd, output int lat, output int rh, output int ra);
        logic [3:0] rot_tab [4];
        logic [3:0] pat;
        int         h;
        rot_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        h   = (hold == 16'd0) ? 1 : int'(hold);
        pat = 4'b0001 << key[3:2];
        kd = 0; lat = 0; rh = 0; ra = 0;
        wait_ready(i);
        cmd_valid[i] = 1'b1; cmd_key[i] = key; cmd_hold[i] = hold;
        col_d = rot ? rot_tab[3] : cval;
        @(negedge clk);
        cmd_valid[i] = 1'b0; cmd_key[i] = 4'($urandom); cmd_hold[i] = 16'($urandom);
        if (key_down[i]) kd++;
        col_d = rot ? rot_tab[0] : cval;
        for (int s = 1; s < 200; s++) begin
            @(negedge clk);
            if (key_down[i]) kd++;
            if (row_q[i] != 4'd0) ra++;
            if (s >= BP[i] + 1 && s <= BP[i] + h && row_q[i] == pat) rh++;
            if (cmd_ready[i]) begin lat = s; break; end
            col_d = rot ? rot_tab[s % 4] : cval;
        end
    endtask

    typedef struct {
        int         inst;
        logic [3:0] key;
        logic [15:0] hold;
        bit         rot;
        logic [3:0] col;
        int         kd;
        int         lat;
        int         rh;
        int         ra;
    } vec_t;

    // ---------------- main sequence ----------------
    initial begin
        vec_t       tab [9];
        int         kd, lat, rh, ra, n;
        bit [7:0]   b_exp;
        logic       r [27];

        n_checks = 0;
        n_errors = 0;

        // inst, key, hold, rotate, col, kd cycles, ready latency, rows in HOLD window, rows total (-1 = free)
        tab[0] = '{1, 4'b1001, 16'd10, 1'b0, 4'b0010, 10, 22, 10, -1};
        tab[1] = '{1, 4'b1001, 16'd10, 1'b1, 4'b0000, 10, 22,  3, -1};
        tab[2] = '{1, 4'b1001, 16'd10, 1'b0, 4'b1101, 10, 22,  0,  0};
        tab[3] = '{1, 4'b1001, 16'd10, 1'b0, 4'b0011, 10, 22, 10, -1};
        tab[4] = '{1, 4'b1001, 16'd0,  1'b0, 4'b0010,  1, 13,  1, -1};
        tab[5] = '{0, 4'b0110, 16'd5,  1'b0, 4'b0100,  5, 10,  5, -1};
        tab[6] = '{2, 4'b1111, 16'd3,  1'b0, 4'b1000,  3, 23,  3, -1};
        tab[7] = '{0, 4'b0000, 16'd1,  1'b0, 4'b0000,  1,  6,  0,  0};
        tab[8] = '{2, 4'b0111, 16'd7,  1'b0, 4'b0111,  7, 27,  0,  0};

        nrst  = 1'b0;
        col_d = 4'd0;
        cmd_valid = 3'b000;
        for (int i = 0; i < 3; i++) begin cmd_key[i] = 4'd0; cmd_hold[i] = 16'd0; end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_row%0d", i),   int'(row_q[i]), 0);
            check($sformatf("reset_kd%0d", i),    int'(key_down[i]), 0);
            check($sformatf("reset_ready%0d", i), int'(cmd_ready[i]), 1);
            check($sformatf("reset_busy%0d", i),  int'(busy[i]), 0);
        end
        nrst = 1'b1;
        fork monitor(); join_none
        @(negedge clk);

        // Reset mid-HOLD on the B=2,G=1 instance.
        cmd_valid[0] = 1'b1; cmd_key[0] = 4'b0110; cmd_hold[0] = 16'd5; col_d = 4'b0100;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        n = 0;
        while (!key_down[0] && n < 50) begin @(negedge clk); n++; end
        check("midhold_reached", int'(key_down[0]), 1);
        @(negedge clk); @(negedge clk);
        check("midhold_row_before_reset", int'(row_q[0]), 4'b0010);
        @(posedge clk); #2;
        nrst = 1'b0;
        #1;
        check("midhold_async_row",   int'(row_q[0]), 0);
        check("midhold_async_kd",    int'(key_down[0]), 0);
        check("midhold_async_ready", int'(cmd_ready[0]), 1);
        check("midhold_async_busy",  int'(busy[0]), 0);
        @(negedge clk); @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Press bounce on the B=8 instance straight from the seed: lfsr[0] of
        // A5,4A,95,2A,54,A9,53,A7 = 1,0,1,0,0,1,1,1.
        b_exp = 8'b1110_0101;
        wait_ready(2);
        col_d = 4'b1111; cmd_valid[2] = 1'b1; cmd_key[2] = 4'b0000; cmd_hold[2] = 16'd3;
        @(negedge clk);
        cmd_valid[2] = 1'b0;
        for (int s = 1; s <= 8; s++) begin
            @(negedge clk);
            check($sformatf("bounce_press_s%0d", s), int'(row_q[2]), b_exp[s-1] ? 1 : 0);
        end
        wait_ready(2);
        check("bounce_ready_back", int'(cmd_ready[2]), 1);

        // Table of directed commands.
        for (int t = 0; t < 9; t++) begin
            run_txn(tab[t].inst, tab[t].key, tab[t].hold, tab[t].rot, tab[t].col, kd, lat, rh, ra);
            check($sformatf("tab%0d_keydown_cycles", t), kd,  tab[t].kd);
            check($sformatf("tab%0d_ready_latency", t),  lat, tab[t].lat);
            check($sformatf("tab%0d_row_in_hold", t),    rh,  tab[t].rh);
            if (tab[t].ra >= 0) check($sformatf("tab%0d_row_total", t), ra, tab[t].ra);
        end

        // Zero hold with cmd_valid held high: back-to-back acceptance at the first ready edge.
        wait_ready(1);
        cmd_valid[1] = 1'b1; cmd_key[1] = 4'b1001; cmd_hold[1] = 16'd0; col_d = 4'b0010;
        kd = 0; n = 0;
        for (int s = 0; s < 27; s++) begin
            @(negedge clk);
            r[s] = cmd_ready[1];
            if (key_down[1]) kd++;
            if (cmd_ready[1]) n++;
        end
        cmd_valid[1] = 1'b0;
        check("heldvalid_ready_s12", int'(r[12]), 0);
        check("heldvalid_ready_s13", int'(r[13]), 1);
        check("heldvalid_ready_s14", int'(r[14]), 0);
        check("heldvalid_keydown_cycles", kd, 2);
        check("heldvalid_ready_samples", n, 1);
        wait_ready(1);

        // Random traffic on all instances against the model, with one asynchronous reset.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            col_d = 4'($urandom);
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) cmd_valid[i] = ~cmd_valid[i];
                cmd_key[i]  = 4'($urandom);
                cmd_hold[i] = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
            end
            if (c == 700) begin
                #2 nrst = 1'b0;
                @(negedge clk);
                nrst = 1'b1;
            end
        end
        cmd_valid = 3'b000;
        repeat (80) @(negedge clk);
        for (int i = 0; i < 3; i++) check($sformatf("drain_ready%0d", i), int'(cmd_ready[i]), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
